// File: rtl/music_pkg.sv
// Shared widths and scheduler state encoding for the music playback blocks.
package music_pkg;

   localparam int NOTE_W = 6;
   localparam int DUR_W  = 6;

   localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ALLOC   = 2'd1,
      S_ADVANCE = 2'd2,
      S_DONE    = 2'd3
   } sched_state_e;

endpackage

// File: rtl/voice_picker.sv
// Combinational voice chooser: lowest-index free voice, otherwise the voice
// closest to finishing (lowest index wins ties), flagged as a steal.
module voice_picker
   import music_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int VIDX_W     = 2
) (
   input  logic [NUM_VOICES-1:0][DUR_W-1:0] remaining,
   output logic [VIDX_W-1:0]                sel,
   output logic                             any_free,
   output logic                             steal
);

   logic [VIDX_W-1:0] free_idx_s;
   logic [VIDX_W-1:0] min_idx_s;
   logic [DUR_W-1:0]  min_val_s;
   logic              free_s;

   // Scan from the top down so the lowest index is the last one to claim a slot.
   always_comb begin
      free_idx_s = '0;
      min_idx_s  = '0;
      min_val_s  = '1;
      free_s     = 1'b0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         free_idx_s = (remaining[i] == '0) ? VIDX_W'(i) : free_idx_s;
         free_s     = free_s | (remaining[i] == '0);
         min_idx_s  = (remaining[i] <= min_val_s) ? VIDX_W'(i) : min_idx_s;
         min_val_s  = (remaining[i] <= min_val_s) ? remaining[i] : min_val_s;
      end
      sel      = free_s ? free_idx_s : min_idx_s;
      any_free = free_s;
      steal    = ~free_s;
   end

endmodule

// File: rtl/voice_scheduler.sv
// Schedules song_reader notes onto a bank of note_player voices, tracking
// per-voice sustain and the beat delay before the next note may issue.
module voice_scheduler
   import music_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int VIDX_W     = $clog2(NUM_VOICES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reset_player,
   input  logic                  play_enable,
   input  logic                  beat,
   input  logic                  load_new_note,
   input  logic [NOTE_W-1:0]     note_to_load,
   input  logic [DUR_W-1:0]      duration_to_load,
   input  logic [DUR_W-1:0]      advance_to_load,
   output logic                  note_done,
   output logic [NUM_VOICES-1:0] voice_load,
   output logic [NOTE_W-1:0]     voice_note,
   output logic [DUR_W-1:0]      voice_duration,
   output logic [NUM_VOICES-1:0] voice_active,
   output logic                  steal_event
);

   sched_state_e                    state_q, state_d;
   logic [DUR_W-1:0]                adv_q, adv_d;
   logic [NUM_VOICES-1:0][DUR_W-1:0] rem_q, rem_d;
   logic [VIDX_W-1:0]               sel_q, sel_d;
   logic                            alloc_q, alloc_d;
   logic [NOTE_W-1:0]               note_q, note_d;
   logic [DUR_W-1:0]                dur_q, dur_d;
   logic [NUM_VOICES-1:0]           load_q, load_d;
   logic [NUM_VOICES-1:0]           active_q, active_d;
   logic                            steal_q, steal_d;
   logic                            done_q, done_d;

   logic [VIDX_W-1:0]               pick_sel_s;
   logic                            pick_free_s;
   logic                            pick_steal_s;
   logic                            tick_s;
   logic                            alloc_wr_s;

   voice_picker #(
      .NUM_VOICES (NUM_VOICES),
      .VIDX_W     (VIDX_W)
   ) u_picker (
      .remaining (rem_q),
      .sel       (pick_sel_s),
      .any_free  (pick_free_s),
      .steal     (pick_steal_s)
   );

   assign tick_s     = beat & play_enable;
   assign alloc_wr_s = (state_q == S_ALLOC) & play_enable & alloc_q;

   // Sustain counters: the voice being allocated takes its new duration instead of a beat.
   always_comb begin
      rem_d    = rem_q;
      active_d = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (alloc_wr_s && (sel_q == VIDX_W'(i))) begin
            rem_d[i] = dur_q;
         end else if (tick_s && (rem_q[i] != '0)) begin
            rem_d[i] = rem_q[i] - DUR_W'(1);
         end else begin
            rem_d[i] = rem_q[i];
         end
         active_d[i] = (rem_q[i] != '0);
      end
   end

   // Scheduler FSM; nothing moves while playback is paused.
   always_comb begin
      state_d = state_q;
      adv_d   = adv_q;
      sel_d   = sel_q;
      alloc_d = alloc_q;
      note_d  = note_q;
      dur_d   = dur_q;
      load_d  = '0;
      steal_d = 1'b0;
      done_d  = 1'b0;
      if (play_enable) begin
         case (state_q)
            S_IDLE: begin
               if (load_new_note) begin
                  state_d = S_ALLOC;
                  adv_d   = advance_to_load;
                  alloc_d = (note_to_load != NOTE_REST);
                  if (note_to_load != NOTE_REST) begin
                     sel_d   = pick_sel_s;
                     note_d  = note_to_load;
                     dur_d   = duration_to_load;
                     load_d  = {{(NUM_VOICES-1){1'b0}}, 1'b1} << pick_sel_s;
                     steal_d = pick_steal_s & ~pick_free_s;
                  end else begin
                     load_d  = '0;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_ALLOC: begin
               if (adv_q == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ADVANCE;
               end
            end
            S_ADVANCE: begin
               if (adv_q == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if (beat) begin
                  adv_d = adv_q - DUR_W'(1);
                  if (adv_q == DUR_W'(1)) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_ADVANCE;
                  end
               end else begin
                  adv_d = adv_q;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers with async power-on clear and sync player clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         adv_q    <= '0;
         rem_q    <= '0;
         sel_q    <= '0;
         alloc_q  <= 1'b0;
         note_q   <= '0;
         dur_q    <= '0;
         load_q   <= '0;
         active_q <= '0;
         steal_q  <= 1'b0;
         done_q   <= 1'b0;
      end else if (reset_player) begin
         state_q  <= S_IDLE;
         adv_q    <= '0;
         rem_q    <= '0;
         sel_q    <= '0;
         alloc_q  <= 1'b0;
         note_q   <= '0;
         dur_q    <= '0;
         load_q   <= '0;
         active_q <= '0;
         steal_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         adv_q    <= adv_d;
         rem_q    <= rem_d;
         sel_q    <= sel_d;
         alloc_q  <= alloc_d;
         note_q   <= note_d;
         dur_q    <= dur_d;
         load_q   <= load_d;
         active_q <= active_d;
         steal_q  <= steal_d;
         done_q   <= done_d;
      end
   end

   assign note_done      = done_q;
   assign voice_load     = load_q;
   assign voice_note     = note_q;
   assign voice_duration = dur_q;
   assign voice_active   = active_q;
   assign steal_event    = steal_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: allocation, chords, stealing, rests,
// pause behaviour and both reset paths.
module tb_voice_scheduler;

   logic       clk;
   logic       reset;
   logic       reset_player;
   logic       play_enable;
   logic       beat;
   logic       load_new_note;
   logic [5:0] note_to_load;
   logic [5:0] duration_to_load;
   logic [5:0] advance_to_load;
   logic       note_done;
   logic [3:0] voice_load;
   logic [5:0] voice_note;
   logic [5:0] voice_duration;
   logic [3:0] voice_active;
   logic       steal_event;

   int total;
   int bad;

   voice_scheduler #(.NUM_VOICES(4), .VIDX_W(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .reset_player     (reset_player),
      .play_enable      (play_enable),
      .beat             (beat),
      .load_new_note    (load_new_note),
      .note_to_load     (note_to_load),
      .duration_to_load (duration_to_load),
      .advance_to_load  (advance_to_load),
      .note_done        (note_done),
      .voice_load       (voice_load),
      .voice_note       (voice_note),
      .voice_duration   (voice_duration),
      .voice_active     (voice_active),
      .steal_event      (steal_event)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic give_beat();
      beat = 1'b1;
      @(negedge clk);
      beat = 1'b0;
   endtask

   task automatic issue(input logic [5:0] n, input logic [5:0] d, input logic [5:0] a);
      note_to_load     = n;
      duration_to_load = d;
      advance_to_load  = a;
      load_new_note    = 1'b1;
      @(negedge clk);
      load_new_note    = 1'b0;
   endtask

   task automatic clear_player();
      reset_player = 1'b1;
      @(negedge clk);
      reset_player = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if ({note_done, voice_load, voice_note, voice_duration, voice_active, steal_event} !== 23'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want 0",
                  {note_done, voice_load, voice_note, voice_duration, voice_active, steal_event});
      end
   endtask

   task automatic test_single();
      clear_player();
      issue(6'd12, 6'd4, 6'd4);
      total++;
      if (voice_load !== 4'b0001 || voice_note !== 6'd12 || voice_duration !== 6'd4) begin
         bad++;
         $display("FAIL single_load: got %b/%0d/%0d want 0001/12/4", voice_load, voice_note, voice_duration);
      end
      tick();
      total++;
      if (voice_load !== 4'b0000) begin
         bad++;
         $display("FAIL single_load_pulse: got %b want 0000", voice_load);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         give_beat();
         total++;
         if (voice_active !== 4'b0001 || note_done !== 1'b0) begin
            bad++;
            $display("FAIL single_sustain beat%0d: got %b/%b want 0001/0", k + 1, voice_active, note_done);
         end
      end
      give_beat();
      total++;
      if (note_done !== 1'b1 || voice_active !== 4'b0001) begin
         bad++;
         $display("FAIL single_done: got %b/%b want 1/0001", note_done, voice_active);
      end
      tick();
      total++;
      if (note_done !== 1'b0 || voice_active !== 4'b0000) begin
         bad++;
         $display("FAIL single_release: got %b/%b want 0/0000", note_done, voice_active);
      end
   endtask

   task automatic test_chord();
      logic [5:0] notes [3];
      logic [3:0] loads [3];
      notes = '{6'd10, 6'd14, 6'd17};
      loads = '{4'b0001, 4'b0010, 4'b0100};
      clear_player();
      for (int k = 0; k < 3; k++) begin
         issue(notes[k], 6'd8, (k == 2) ? 6'd8 : 6'd0);
         total++;
         if (voice_load !== loads[k] || voice_note !== notes[k]) begin
            bad++;
            $display("FAIL chord_load%0d: got %b/%0d want %b/%0d", k, voice_load, voice_note, loads[k], notes[k]);
         end
         tick();
         if (k < 2) begin
            total++;
            if (note_done !== 1'b1) begin
               bad++;
               $display("FAIL chord_done%0d: got %b want 1", k, note_done);
            end
            tick();
         end
      end
      tick();
      for (int k = 0; k < 7; k++) begin
         give_beat();
         total++;
         if (voice_active !== 4'b0111 || note_done !== 1'b0) begin
            bad++;
            $display("FAIL chord_sustain beat%0d: got %b/%b want 0111/0", k + 1, voice_active, note_done);
         end
      end
      give_beat();
      total++;
      if (note_done !== 1'b1) begin
         bad++;
         $display("FAIL chord_final_done: got %b want 1", note_done);
      end
      tick();
      total++;
      if (voice_active !== 4'b0000) begin
         bad++;
         $display("FAIL chord_release: got %b want 0000", voice_active);
      end
   endtask

   task automatic test_steal();
      logic [5:0] durs [4];
      durs = '{6'd5, 6'd3, 6'd7, 6'd3};
      clear_player();
      for (int k = 0; k < 4; k++) begin
         issue(6'(k + 1), durs[k], 6'd0);
         total++;
         if (voice_load !== (4'b0001 << k) || steal_event !== 1'b0) begin
            bad++;
            $display("FAIL steal_fill%0d: got %b/%b want %b/0", k, voice_load, steal_event, 4'b0001 << k);
         end
         tick();
         tick();
      end
      issue(6'd5, 6'd6, 6'd0);
      total++;
      if (voice_load !== 4'b0010 || steal_event !== 1'b1 || voice_note !== 6'd5) begin
         bad++;
         $display("FAIL steal_pick: got %b/%b/%0d want 0010/1/5", voice_load, steal_event, voice_note);
      end
      tick();
      total++;
      if (steal_event !== 1'b0) begin
         bad++;
         $display("FAIL steal_pulse: got %b want 0", steal_event);
      end
      tick();
   endtask

   task automatic test_rest();
      clear_player();
      issue(6'd12, 6'd3, 6'd0);
      tick();
      tick();
      issue(6'd0, 6'd9, 6'd2);
      total++;
      if (voice_load !== 4'b0000 || steal_event !== 1'b0) begin
         bad++;
         $display("FAIL rest_no_load: got %b/%b want 0000/0", voice_load, steal_event);
      end
      tick();
      total++;
      if (voice_active !== 4'b0001) begin
         bad++;
         $display("FAIL rest_no_alloc: got %b want 0001", voice_active);
      end
      give_beat();
      total++;
      if (note_done !== 1'b0) begin
         bad++;
         $display("FAIL rest_early_done: got %b want 0", note_done);
      end
      give_beat();
      total++;
      if (note_done !== 1'b1 || voice_active !== 4'b0001) begin
         bad++;
         $display("FAIL rest_done: got %b/%b want 1/0001", note_done, voice_active);
      end
      give_beat();
      tick();
      total++;
      if (voice_active !== 4'b0000) begin
         bad++;
         $display("FAIL rest_decay: got %b want 0000", voice_active);
      end
   endtask

   task automatic test_freeze();
      clear_player();
      issue(6'd20, 6'd3, 6'd3);
      tick();
      tick();
      give_beat();
      play_enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         give_beat();
         total++;
         if (voice_active !== 4'b0001 || note_done !== 1'b0) begin
            bad++;
            $display("FAIL freeze_hold beat%0d: got %b/%b want 0001/0", k + 1, voice_active, note_done);
         end
      end
      play_enable = 1'b1;
      give_beat();
      total++;
      if (note_done !== 1'b0 || voice_active !== 4'b0001) begin
         bad++;
         $display("FAIL freeze_resume: got %b/%b want 0/0001", note_done, voice_active);
      end
      give_beat();
      total++;
      if (note_done !== 1'b1) begin
         bad++;
         $display("FAIL freeze_done: got %b want 1", note_done);
      end
      tick();
      total++;
      if (voice_active !== 4'b0000) begin
         bad++;
         $display("FAIL freeze_release: got %b want 0000", voice_active);
      end
   endtask

   task automatic test_reset_mid();
      clear_player();
      issue(6'd30, 6'd9, 6'd0);
      tick();
      tick();
      issue(6'd31, 6'd9, 6'd5);
      tick();
      tick();
      total++;
      if (voice_active !== 4'b0011) begin
         bad++;
         $display("FAIL midreset_busy: got %b want 0011", voice_active);
      end
      give_beat();
      #2 reset = 1'b0;
      #1;
      total++;
      if ({note_done, voice_load, voice_note, voice_duration, voice_active, steal_event} !== 23'd0) begin
         bad++;
         $display("FAIL midreset_clear: got %h want 0",
                  {note_done, voice_load, voice_note, voice_duration, voice_active, steal_event});
      end
      tick();
      tick();
      reset = 1'b1;
      issue(6'd40, 6'd2, 6'd0);
      total++;
      if (voice_load !== 4'b0001 || voice_note !== 6'd40) begin
         bad++;
         $display("FAIL midreset_reload: got %b/%0d want 0001/40", voice_load, voice_note);
      end
      tick();
      total++;
      if (note_done !== 1'b1) begin
         bad++;
         $display("FAIL midreset_done: got %b want 1", note_done);
      end
      tick();
   endtask

   task automatic test_player_clear();
      clear_player();
      issue(6'd5, 6'd4, 6'd0);
      reset_player = 1'b1;
      tick();
      reset_player = 1'b0;
      total++;
      if (note_done !== 1'b0 || voice_load !== 4'b0000 || voice_active !== 4'b0000) begin
         bad++;
         $display("FAIL clear_inflight: got %b/%b/%b want 0/0000/0000", note_done, voice_load, voice_active);
      end
      tick();
      total++;
      if (voice_active !== 4'b0000 || note_done !== 1'b0) begin
         bad++;
         $display("FAIL clear_dropped: got %b/%b want 0000/0", voice_active, note_done);
      end
   endtask

   task automatic test_zero_duration();
      clear_player();
      issue(6'd7, 6'd0, 6'd0);
      total++;
      if (voice_load !== 4'b0001) begin
         bad++;
         $display("FAIL zero_dur_load: got %b want 0001", voice_load);
      end
      tick();
      tick();
      total++;
      if (voice_active !== 4'b0000) begin
         bad++;
         $display("FAIL zero_dur_active: got %b want 0000", voice_active);
      end
      issue(6'd8, 6'd5, 6'd0);
      total++;
      if (voice_load !== 4'b0001 || steal_event !== 1'b0) begin
         bad++;
         $display("FAIL zero_dur_reuse: got %b/%b want 0001/0", voice_load, steal_event);
      end
      tick();
      tick();
   endtask

   initial begin
      total            = 0;
      bad              = 0;
      reset            = 1'b0;
      reset_player     = 1'b0;
      play_enable      = 1'b1;
      beat             = 1'b0;
      load_new_note    = 1'b0;
      note_to_load     = 6'd0;
      duration_to_load = 6'd0;
      advance_to_load  = 6'd0;
      tick();
      tick();
      test_reset();
      reset = 1'b1;
      tick();
      test_single();
      test_chord();
      test_steal();
      test_rest();
      test_freeze();
      test_reset_mid();
      test_player_clear();
      test_zero_duration();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
